flow_count_update: RTL

FLOW_COUNT_UPDATE -- requirements
Module: flow_count_update

---
 rtl/flow_count_update_pkg.sv | 28 ++
 rtl/flow_count_update_epoch_timer.sv | 27 ++
 rtl/flow_count_update.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/flow_count_update_pkg.sv
// Shared definitions for the flow measurement path (count update and dump stages).
// Holds FSM/bank encodings and the default parameter set.
package flow_count_update_pkg;

    localparam int DEF_LENGTH_WIDTH  = 16;
    localparam int DEF_ID_WIDTH      = 12;
    localparam int DEF_COUNTER_WIDTH = 20;
    localparam int DEF_ID_READ_NUMBER = 7;
    localparam int DEF_EPOCH_CYCLES  = 1000;
    localparam int DEF_EPOCH_WIDTH   = 32;

    localparam int DROP_CNT_WIDTH = 16;
    localparam int NUM_BANKS      = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT1,
        S_WAIT2,
        S_CALC,
        S_WRITE
    } state_t;

    typedef enum logic {
        BANK1 = 1'b0,
        BANK2 = 1'b1
    } bank_t;

endpackage

// File: rtl/flow_count_update_epoch_timer.sv
// Free-running epoch timer: counts 0..C_EPOCH_CYCLES-1 and pulses tc on the last count.
module epoch_timer #(
    parameter int C_EPOCH_CYCLES = 1000,
    parameter int C_EPOCH_WIDTH  = 32
) (
    input  logic clk,
    input  logic rst,
    output logic tc
);

    localparam logic [C_EPOCH_WIDTH-1:0] LAST_COUNT = C_EPOCH_WIDTH'(C_EPOCH_CYCLES - 1);

    logic [C_EPOCH_WIDTH-1:0] count_reg;

    assign tc = !rst && (count_reg == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (tc) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + C_EPOCH_WIDTH'(1);
        end
    end

endmodule

// File: rtl/flow_count_update.sv
// Per-flow byte counter update: read-modify-write of a saturating counter into one of
// two ping-pong RAM banks; the banks swap each epoch so the idle one can be drained.
module flow_count_update
    import flow_count_update_pkg::*;
#(
    parameter int C_LENGTH_WIDTH  = DEF_LENGTH_WIDTH,
    parameter int C_ID_WIDTH      = DEF_ID_WIDTH,
    parameter int C_COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter int ID_READ_NUMBER  = DEF_ID_READ_NUMBER,
    // Must be >= 5*(ID_READ_NUMBER+1)+10 so a closed bank is drained within one epoch.
    parameter int C_EPOCH_CYCLES  = DEF_EPOCH_CYCLES,
    parameter int C_EPOCH_WIDTH   = DEF_EPOCH_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [C_ID_WIDTH-1:0]      in_id,
    input  logic [C_LENGTH_WIDTH-1:0]  in_length,
    output logic                       out_ready,
    output logic                       out_ram_en1a,
    output logic                       out_ram_en2a,
    output logic                       out_ram_regce1a,
    output logic                       out_ram_regce2a,
    output logic                       out_ram_wen1a,
    output logic                       out_ram_wen2a,
    output logic [C_ID_WIDTH-1:0]      out_ram_addr1a,
    output logic [C_ID_WIDTH-1:0]      out_ram_addr2a,
    output logic [C_COUNTER_WIDTH-1:0] out_ram_din1a,
    output logic [C_COUNTER_WIDTH-1:0] out_ram_din2a,
    input  logic [C_COUNTER_WIDTH-1:0] in_ram_dout1a,
    input  logic [C_COUNTER_WIDTH-1:0] in_ram_dout2a,
    output logic                       out_ready_read_1,
    output logic                       out_ready_read_2,
    output logic [DROP_CNT_WIDTH-1:0]  out_drop_cnt
);

    localparam logic [C_ID_WIDTH-1:0] MAX_ID = C_ID_WIDTH'(ID_READ_NUMBER);
    localparam int SUM_WIDTH = C_COUNTER_WIDTH + 1;

    state_t                      state_reg, state_next;
    bank_t                       bank_reg;
    bank_t                       bank_lat_reg;
    logic [C_ID_WIDTH-1:0]       id_reg;
    logic [C_LENGTH_WIDTH-1:0]   length_reg;
    logic [C_COUNTER_WIDTH-1:0]  sum_reg;
    logic                        swap_pending_reg;
    logic [DROP_CNT_WIDTH-1:0]   drop_cnt_reg;
    logic                        epoch_tc;

    logic idle;
    logic swap_take;
    logic ready;
    logic accept;
    logic rmw_start;
    logic drop;

    logic [C_COUNTER_WIDTH-1:0] dout_sel;
    logic [SUM_WIDTH-1:0]       sum_wide;
    logic [C_COUNTER_WIDTH-1:0] sat_sum;

    bank_t                      drive_bank;
    logic                       port_en;
    logic                       port_regce;
    logic                       port_wen;
    logic [C_ID_WIDTH-1:0]      port_addr;
    logic [C_COUNTER_WIDTH-1:0] port_din;

    logic [NUM_BANKS-1:0]       bank_en;
    logic [NUM_BANKS-1:0]       bank_regce;
    logic [NUM_BANKS-1:0]       bank_wen;
    logic [C_ID_WIDTH-1:0]      bank_addr [NUM_BANKS];
    logic [C_COUNTER_WIDTH-1:0] bank_din  [NUM_BANKS];

    epoch_timer #(
        .C_EPOCH_CYCLES (C_EPOCH_CYCLES),
        .C_EPOCH_WIDTH  (C_EPOCH_WIDTH)
    ) u_epoch_timer (
        .clk (clk),
        .rst (rst),
        .tc  (epoch_tc)
    );

    // A pending swap blocks acceptance so the bank flips between records, never mid-RMW.
    assign idle      = (state_reg == S_IDLE);
    assign swap_take = idle && swap_pending_reg;
    assign ready     = idle && !swap_pending_reg && !rst;
    assign accept    = in_valid && ready;
    assign rmw_start = accept && (in_id <= MAX_ID);
    assign drop      = accept && (in_id > MAX_ID);

    assign dout_sel = (bank_lat_reg == BANK2) ? in_ram_dout2a : in_ram_dout1a;
    assign sum_wide = {1'b0, dout_sel} + SUM_WIDTH'(length_reg);
    assign sat_sum  = sum_wide[C_COUNTER_WIDTH] ? '1 : sum_wide[C_COUNTER_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (rmw_start) state_next = S_WAIT1;
            S_WAIT1: state_next = S_WAIT2;
            S_WAIT2: state_next = S_CALC;
            S_CALC:  state_next = S_WRITE;
            S_WRITE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Address and enables stay up through the wait states so the registered read holds.
    always_comb begin
        drive_bank = bank_lat_reg;
        port_en    = 1'b0;
        port_regce = 1'b0;
        port_wen   = 1'b0;
        port_addr  = '0;
        port_din   = '0;
        case (state_reg)
            S_IDLE: begin
                drive_bank = bank_reg;
                if (rmw_start) begin
                    port_en    = 1'b1;
                    port_regce = 1'b1;
                    port_addr  = in_id;
                end
            end
            S_WAIT1, S_WAIT2, S_CALC: begin
                port_en    = 1'b1;
                port_regce = 1'b1;
                port_addr  = id_reg;
            end
            S_WRITE: begin
                port_en    = 1'b1;
                port_regce = 1'b1;
                port_wen   = 1'b1;
                port_addr  = id_reg;
                port_din   = sum_reg;
            end
            default: ;
        endcase
        if (rst) begin
            port_en    = 1'b0;
            port_regce = 1'b0;
            port_wen   = 1'b0;
            port_addr  = '0;
            port_din   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_reg         <= BANK1;
            bank_lat_reg     <= BANK1;
            swap_pending_reg <= 1'b0;
            drop_cnt_reg     <= '0;
            id_reg           <= '0;
            length_reg       <= '0;
            sum_reg          <= '0;
        end else begin
            if (swap_take) begin
                bank_reg <= (bank_reg == BANK1) ? BANK2 : BANK1;
            end
            // A terminal count arriving as the swap is taken is absorbed, not queued.
            swap_pending_reg <= swap_take ? 1'b0 : (swap_pending_reg | epoch_tc);
            if (drop) begin
                drop_cnt_reg <= drop_cnt_reg + DROP_CNT_WIDTH'(1);
            end
            if (rmw_start) begin
                id_reg       <= in_id;
                length_reg   <= in_length;
                bank_lat_reg <= bank_reg;
            end
            if (state_reg == S_CALC) begin
                sum_reg <= sat_sum;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        localparam bank_t GI_BANK = bank_t'(gi);
        logic sel;
        assign sel            = (drive_bank == GI_BANK);
        assign bank_en[gi]    = sel & port_en;
        assign bank_regce[gi] = sel & port_regce;
        assign bank_wen[gi]   = sel & port_wen;
        assign bank_addr[gi]  = sel ? port_addr : '0;
        assign bank_din[gi]   = sel ? port_din : '0;
    end

    assign out_ram_en1a    = bank_en[0];
    assign out_ram_en2a    = bank_en[1];
    assign out_ram_regce1a = bank_regce[0];
    assign out_ram_regce2a = bank_regce[1];
    assign out_ram_wen1a   = bank_wen[0];
    assign out_ram_wen2a   = bank_wen[1];
    assign out_ram_addr1a  = bank_addr[0];
    assign out_ram_addr2a  = bank_addr[1];
    assign out_ram_din1a   = bank_din[0];
    assign out_ram_din2a   = bank_din[1];

    assign out_ready        = ready;
    assign out_ready_read_1 = (bank_reg == BANK2);
    assign out_ready_read_2 = (bank_reg == BANK1);
    assign out_drop_cnt     = drop_cnt_reg;

endmodule
